adas_vehicle_model: RTL and testbench
=====================================

ADAS_VEHICLE_MODEL -- requirements
Module: adas_vehicle_model

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 16: clk cycles per control tick, at least 2.
REQ-002 SHALL provide parameter ACC_STEP, default 2: speed increment per tick while gas only.
REQ-003 SHALL provide parameter BRK_STEP, default 4: speed decrement per tick while brake only.
REQ-004 SHALL provide parameter MAX_SPEED, default 200: speed ceiling.
REQ-005 SHALL provide parameter INIT_GAP, default 100: gap to the lead vehicle after reset.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  system clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 start_i  input  1  leave IDLE and begin simulation.
REQ-010 gas_i  input  1  gas command from the ADAS controller.
REQ-011 brake_i  input  1  brake command from the ADAS controller.
REQ-012 lead_speed_i  input  8  speed of the lead vehicle, unsigned.
REQ-013 timer_trick_o  output  1  one-cycle control tick to the ADAS controller.
REQ-014 speed_measured_o  output  8  current ego speed, unsigned.
REQ-015 distance_lidar_o  output  8  lidar gap reading, one tick stale.
REQ-016 distance_cam_o  output  8  camera gap reading, two ticks stale.
REQ-017 collision_o  output  1  latched collision flag.
REQ-018 state_o  output  2  current state: 00 IDLE, 01 RUN, 10 COLLISION.

Function
REQ-019 States SHALL be IDLE, RUN and COLLISION. Transitions: IDLE->RUN when start_i=1; RUN->COLLISION on the tick whose gap update yields 0. COLLISION exits only via rst. start_i SHALL be ignored outside IDLE.
REQ-020 Tick counter SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, and be zero on RUN entry.
REQ-021 timer_trick_o SHALL be 1 exactly when state=RUN and counter=TICK_DIV-1; the first tick falls TICK_DIV cycles after the RUN-entry edge.
REQ-022 On a tick cycle, speed and gap SHALL update at that clock edge using gas_i, brake_i and lead_speed_i sampled at that cycle; new values are visible the next cycle.
REQ-023 Speed update SHALL follow the pedals: gas only gives +ACC_STEP saturating at MAX_SPEED; brake only gives -BRK_STEP saturating at 0; both give hold; neither gives -1 coast saturating at 0.
REQ-024 Gap update SHALL compute diff = lead_speed_i - speed as 9-bit signed using the pre-update speed, then delta = diff arithmetic-shift-right 3 (floor). New gap = gap + delta, clamped to 0..255.
REQ-025 On each tick, lidar SHALL load the pre-update gap, and camera SHALL load the previous lidar value (a 2-stage pipe).
REQ-026 Entering COLLISION SHALL force speed to 0, set collision_o=1, stop ticks, and freeze gap and sensor registers.
REQ-027 In IDLE, no ticks SHALL occur and speed, gap and sensor registers SHALL hold.

Reset
REQ-028 rst=1 SHALL set state IDLE, counter 0, speed_measured_o 0, gap INIT_GAP, distance_lidar_o and distance_cam_o INIT_GAP, collision_o 0, timer_trick_o 0.
REQ-029 rst SHALL override every other event, including a tick, start_i, or a collision, in the same cycle.

Verification
REQ-030 rst, start_i pulse at cycle k -> state_o=01 at k+1; timer_trick_o high at k+16, k+32, k+48, each 1 cycle wide.
REQ-031 gas=1, brake=0, lead_speed_i=0 -> speed 0,2,4,...; reaches 200 after 100 ticks and stays 200; gas=0, brake=1 -> 200,196,...,0 and holds 0.
REQ-032 speed 10 with gas=brake=1 -> holds 10; then both 0 -> 9,8,...,0, holds 0.
REQ-033 speed 0, lead_speed_i=40, no pedals -> gap 100->105->110; lidar shows 100,105 and camera 100,100,105 on successive ticks; speed 7 with lead 0 -> delta -1.
REQ-034 Gap driven to 0 -> state_o=10, collision_o=1, speed 0, no further ticks, start_i ignored; rst -> IDLE with all reset values.
REQ-035 rst asserted on a tick cycle mid-RUN -> no speed/gap update, all REQ-028 values next cycle.

Source files
------------

// File: rtl/adas_vehicle_model.sv
// ADAS plant model: ego-vehicle speed, gap to the lead vehicle, and two
// delayed gap sensors, all advanced once per control tick while running.
module adas_vehicle_model #(
    parameter int TICK_DIV  = 16,
    parameter int ACC_STEP  = 2,
    parameter int BRK_STEP  = 4,
    parameter int MAX_SPEED = 200,
    parameter int INIT_GAP  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       gas_i,
    input  logic       brake_i,
    input  logic [7:0] lead_speed_i,
    output logic       timer_trick_o,
    output logic [7:0] speed_measured_o,
    output logic [7:0] distance_lidar_o,
    output logic [7:0] distance_cam_o,
    output logic       collision_o,
    output logic [1:0] state_o
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_COLL = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      speed_q, speed_d;
    logic [7:0]      gap_q, gap_d;
    logic [7:0]      lidar_q, cam_q;
    logic            tick;

    logic [9:0]        speed_up;
    logic signed [8:0] diff;
    logic signed [8:0] delta;
    logic signed [9:0] gap_sum;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: start leaves IDLE, a tick that drives the gap to 0 collides.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (tick && gap_d == 8'd0) state_d = S_COLL;
            S_COLL:  state_d = S_COLL;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: tick strobe, collision flag and state encoding.
    always_comb begin
        tick          = (state_q == S_RUN) && (cnt_q == CW'(TICK_DIV - 1));
        timer_trick_o = tick;
        collision_o   = (state_q == S_COLL);
        state_o       = state_q;
    end

    // Plant arithmetic: pedal-driven speed step and clamped gap integration.
    always_comb begin
        speed_up = {2'b00, speed_q} + 10'(ACC_STEP);
        speed_d  = speed_q;
        if (gas_i && !brake_i) begin
            speed_d = (speed_up > 10'(MAX_SPEED)) ? 8'(MAX_SPEED) : speed_up[7:0];
        end else if (brake_i && !gas_i) begin
            speed_d = (speed_q < 8'(BRK_STEP)) ? 8'd0 : speed_q - 8'(BRK_STEP);
        end else if (!gas_i && !brake_i) begin
            speed_d = (speed_q == 8'd0) ? 8'd0 : speed_q - 8'd1;
        end

        // Relative speed uses the pre-update ego speed; >>> floors toward -inf.
        diff    = $signed({1'b0, lead_speed_i}) - $signed({1'b0, speed_q});
        delta   = diff >>> 3;
        gap_sum = $signed({2'b00, gap_q}) + $signed({delta[8], delta});
        if (gap_sum < 0)             gap_d = 8'd0;
        else if (gap_sum > 10'sd255) gap_d = 8'd255;
        else                         gap_d = gap_sum[7:0];
    end

    // Tick counter: runs only in RUN, so it is zero whenever RUN is entered.
    always_ff @(posedge clk) begin
        if (rst)                  cnt_q <= '0;
        else if (state_q != S_RUN) cnt_q <= '0;
        else if (tick)            cnt_q <= '0;
        else                      cnt_q <= cnt_q + CW'(1);
    end

    // Plant registers: advance on ticks only; a colliding tick zeroes speed.
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q <= 8'd0;
            gap_q   <= 8'(INIT_GAP);
            lidar_q <= 8'(INIT_GAP);
            cam_q   <= 8'(INIT_GAP);
        end else if (tick) begin
            speed_q <= (gap_d == 8'd0) ? 8'd0 : speed_d;
            gap_q   <= gap_d;
            lidar_q <= gap_q;
            cam_q   <= lidar_q;
        end
    end

    assign speed_measured_o = speed_q;
    assign distance_lidar_o = lidar_q;
    assign distance_cam_o   = cam_q;

endmodule

// File: tb/tb_adas_vehicle_model.sv
// Directed self-checking bench for adas_vehicle_model with default parameters.
module tb_adas_vehicle_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       gas_i;
    logic       brake_i;
    logic [7:0] lead_speed_i;
    logic       timer_trick_o;
    logic [7:0] speed_measured_o;
    logic [7:0] distance_lidar_o;
    logic [7:0] distance_cam_o;
    logic       collision_o;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;

    adas_vehicle_model dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .gas_i            (gas_i),
        .brake_i          (brake_i),
        .lead_speed_i     (lead_speed_i),
        .timer_trick_o    (timer_trick_o),
        .speed_measured_o (speed_measured_o),
        .distance_lidar_o (distance_lidar_o),
        .distance_cam_o   (distance_cam_o),
        .collision_o      (collision_o),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs settle #1 after it and inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the tick strobe is visible in the current cycle.
    task automatic wait_visible();
        int n;
        n = 0;
        while (timer_trick_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (timer_trick_o !== 1'b1) begin
            check("tick_timeout", 32'(timer_trick_o), 32'd1);
        end
    endtask

    // Let exactly one tick update take place.
    task automatic wait_tick();
        wait_visible();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        int ticks;
        rst = 1'b1; start_i = 1'b0; gas_i = 1'b0; brake_i = 1'b0; lead_speed_i = 8'd0;
        repeat (3) step();

        // Reset values.
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_speed", 32'(speed_measured_o), 32'd0);
        check("rst_lidar", 32'(distance_lidar_o), 32'd100);
        check("rst_cam", 32'(distance_cam_o), 32'd100);
        check("rst_coll", 32'(collision_o), 32'd0);
        check("rst_tick", 32'(timer_trick_o), 32'd0);
        rst = 1'b0;

        // IDLE: no ticks without start.
        ticks = 0;
        repeat (40) begin step(); if (timer_trick_o) ticks++; end
        check("idle_no_ticks", 32'(ticks), 32'd0);
        check("idle_state", 32'(state_o), 32'd0);

        // Start pulse and tick spacing.
        start_pulse();
        check("run_entry", 32'(state_o), 32'd1);
        repeat (14) step();
        check("tick1_early", 32'(timer_trick_o), 32'd0);
        step();
        check("tick1", 32'(timer_trick_o), 32'd1);
        step();
        check("tick1_width", 32'(timer_trick_o), 32'd0);
        repeat (14) step();
        check("tick2_early", 32'(timer_trick_o), 32'd0);
        step();
        check("tick2", 32'(timer_trick_o), 32'd1);
        step();
        repeat (15) step();
        check("tick3", 32'(timer_trick_o), 32'd1);

        // Gas ramp to the ceiling (lead fast so the gap only grows).
        gas_i = 1'b1; lead_speed_i = 8'd255;
        wait_tick();
        check("gas_first", 32'(speed_measured_o), 32'd2);
        repeat (98) wait_tick();
        check("gas_99", 32'(speed_measured_o), 32'd198);
        wait_tick();
        check("gas_100", 32'(speed_measured_o), 32'd200);
        wait_tick();
        check("gas_sat", 32'(speed_measured_o), 32'd200);
        check("gap_clamp_hi_lidar", 32'(distance_lidar_o), 32'd255);
        check("gap_clamp_hi_cam", 32'(distance_cam_o), 32'd255);

        // Brake down to zero.
        gas_i = 1'b0; brake_i = 1'b1;
        wait_tick();
        check("brake_first", 32'(speed_measured_o), 32'd196);
        repeat (48) wait_tick();
        check("brake_49", 32'(speed_measured_o), 32'd4);
        wait_tick();
        check("brake_zero", 32'(speed_measured_o), 32'd0);
        wait_tick();
        check("brake_sat", 32'(speed_measured_o), 32'd0);

        // Both pedals hold, none coasts.
        gas_i = 1'b1; brake_i = 1'b0;
        repeat (5) wait_tick();
        check("gas_to_10", 32'(speed_measured_o), 32'd10);
        brake_i = 1'b1;
        repeat (3) wait_tick();
        check("both_hold", 32'(speed_measured_o), 32'd10);
        gas_i = 1'b0; brake_i = 1'b0;
        wait_tick();
        check("coast_first", 32'(speed_measured_o), 32'd9);
        repeat (9) wait_tick();
        check("coast_zero", 32'(speed_measured_o), 32'd0);
        wait_tick();
        check("coast_sat", 32'(speed_measured_o), 32'd0);

        // Gap growth and sensor staleness: speed 0, lead 40 -> +5 per tick.
        do_reset();
        check("rst2_lidar", 32'(distance_lidar_o), 32'd100);
        lead_speed_i = 8'd40;
        start_pulse();
        wait_tick();
        check("sens1_lidar", 32'(distance_lidar_o), 32'd100);
        check("sens1_cam", 32'(distance_cam_o), 32'd100);
        wait_tick();
        check("sens2_lidar", 32'(distance_lidar_o), 32'd105);
        check("sens2_cam", 32'(distance_cam_o), 32'd100);
        wait_tick();
        check("sens3_lidar", 32'(distance_lidar_o), 32'd110);
        check("sens3_cam", 32'(distance_cam_o), 32'd105);

        // Collision: lead stopped, ego accelerating. Gap before ticks 26..28
        // is 16, 9, 2; tick 28 yields -5, clamped to 0.
        do_reset();
        lead_speed_i = 8'd0; gas_i = 1'b1;
        start_pulse();
        repeat (27) wait_tick();
        check("pre_coll_speed", 32'(speed_measured_o), 32'd54);
        check("pre_coll_lidar", 32'(distance_lidar_o), 32'd9);
        check("pre_coll_cam", 32'(distance_cam_o), 32'd16);
        check("pre_coll_state", 32'(state_o), 32'd1);
        wait_tick();
        check("coll_state", 32'(state_o), 32'd2);
        check("coll_flag", 32'(collision_o), 32'd1);
        check("coll_speed", 32'(speed_measured_o), 32'd0);
        check("coll_lidar", 32'(distance_lidar_o), 32'd2);
        check("coll_cam", 32'(distance_cam_o), 32'd9);
        start_i = 1'b1;
        ticks = 0;
        repeat (40) begin step(); if (timer_trick_o) ticks++; end
        start_i = 1'b0;
        check("coll_no_ticks", 32'(ticks), 32'd0);
        check("coll_start_ignored", 32'(state_o), 32'd2);
        check("coll_frozen_lidar", 32'(distance_lidar_o), 32'd2);
        do_reset();
        check("coll_rst_state", 32'(state_o), 32'd0);
        check("coll_rst_flag", 32'(collision_o), 32'd0);
        check("coll_rst_lidar", 32'(distance_lidar_o), 32'd100);
        check("coll_rst_cam", 32'(distance_cam_o), 32'd100);

        // Reset on a tick cycle beats the update.
        gas_i = 1'b1;
        start_pulse();
        repeat (3) wait_tick();
        check("mid_speed", 32'(speed_measured_o), 32'd6);
        wait_visible();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("tickrst_speed", 32'(speed_measured_o), 32'd0);
        check("tickrst_state", 32'(state_o), 32'd0);
        check("tickrst_lidar", 32'(distance_lidar_o), 32'd100);
        check("tickrst_cam", 32'(distance_cam_o), 32'd100);
        check("tickrst_tick", 32'(timer_trick_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
